mlx90640_subpage_scanner: RTL
=============================

# mlx90640_subpage_scanner

Sequencing reader for the MLX90640 subpage/offset ROM set. On a start pulse it walks ROM addresses and applies the ROM's 1-cycle read latency. It filters pixels by the chess-pattern bit of the selected subpage and streams each selected pixel's address and 16-bit offset over a valid/ready interface. It sits between the subpage ROMs and the per-pixel compensation pipeline.

## Interface
Parameters:
- DEPTH, 832: ROM depth, 768 pixels plus 64 auxiliary words.
- PIXELS, 768: number of pixel addresses (32x24).
- ADDRW, $clog2(DEPTH): address width (localparam).

Ports:
- clk  in  1  system clock; only clock.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  scan request pulse; ignored unless idle.
- subpage  in  1  subpage to select (0/1); latched at accepted start.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse at scan completion.
- rom_addr  out  ADDRW  registered ROM address.
- rom_pg0  in  1  subpage-0 pattern bit; valid 1 cycle after rom_addr.
- rom_pg1  in  1  subpage-1 pattern bit; valid 1 cycle after rom_addr.
- rom_offset  in  16  pixel offset word; valid 1 cycle after rom_addr.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accept.
- out_addr  out  ADDRW  address of emitted beat.
- out_offset  out  16  offset of emitted beat, passed unmodified.
- out_aux  out  1  beat is an auxiliary word; only when MLX_SCAN_AUX_EN is defined, otherwise tied 0.

## Operation
- FSM states: IDLE, ADDR, DATA, OUT, DONE.
- IDLE: on start=1, latch subpage, set rom_addr=0, set busy=1, go to ADDR.
- ADDR: rom_addr is stable, and the ROM samples it at the end of this cycle. Go to DATA.
- DATA: ROM outputs are valid. Select bit = the latched subpage ? rom_pg1 : rom_pg0.
  - Selected: load out_addr=rom_addr and out_offset=rom_offset, set out_valid=1, go to OUT.
  - Not selected: advance.
- OUT: hold out_valid and all payload stable until out_ready=1. On the handshake cycle, clear out_valid and advance.
- Advance: if rom_addr is the last scanned address, go to DONE. Otherwise increment rom_addr and go to ADDR.
- Last scanned address is PIXELS-1, or DEPTH-1 when MLX_SCAN_AUX_EN is defined.
- DONE: done=1 for one cycle, busy=0, go to IDLE.
- start while busy: ignored and not queued.
- A change on subpage mid-scan has no effect.
- rst at any time: FSM returns to IDLE next edge, and all outputs take their reset values. Any in-flight beat is dropped.

## Timing
- Reset values: busy=0, done=0, out_valid=0, out_addr=0, out_offset=0, out_aux=0, rom_addr=0.
- All outputs are registered; there is no combinational path from out_ready to any output.
- Per pixel: a skipped pixel costs 2 cycles (ADDR, DATA). A selected pixel costs 3 cycles plus any out_ready stall cycles.
- out_valid rises the cycle after DATA. With out_ready held high, it stays high for exactly 1 cycle per beat.
- Start accepted at edge t0: first ADDR cycle is t0+1. DONE occurs in the cycle after the last pixel's final state.
- done and out_valid are never high in the same cycle.

## Configuration
- Macro MLX_SCAN_AUX_EN.
- Defined: after the pixel region, addresses PIXELS..DEPTH-1 are emitted unconditionally. The pattern bits are ignored and out_aux=1 on those beats.
- Not defined: the scan ends at PIXELS-1, aux addresses are never issued, and out_aux is constant 0.
- Pixel-region behaviour is identical in both builds.

## Test plan
Bench ROM model: 1-cycle latency, pg0=~addr[0], pg1=addr[0], offset=addr*3.
- Reset, then subpage=0 start, out_ready=1 -> 384 beats, out_addr 0,2,...,766, out_offset 0,6,...,2298; done pulse at t0+1921; busy low after done.
- subpage=1, out_ready=1 -> 384 beats, first beat addr 1 / offset 3, last beat addr 767 / offset 2301.
- subpage=0 with out_ready low for 5 cycles on beat addr 4 -> out_valid, out_addr=4 and out_offset=12 held stable for 6 cycles; no beat lost or duplicated.
- start pulsed again mid-scan, and subpage toggled -> ignored; the original scan completes with exactly 384 subpage-0 beats.
- rst asserted while in OUT at addr 100 -> next cycle all outputs are at reset values; a new start rescans from addr 0.
- MLX_SCAN_AUX_EN defined, subpage=0 -> 384 pixel beats, then 64 beats at addr 768..831 with out_aux=1 and offset=addr*3; done follows addr 831.

Source files
------------

// File: rtl/mlx90640_subpage_scanner.sv
// Walks the MLX90640 subpage ROM set and streams the pixels of one chess subpage.
// Optional auxiliary-word scan (addresses PIXELS..DEPTH-1) enabled by MLX_SCAN_AUX_EN.
module mlx90640_subpage_scanner #(
   parameter  int DEPTH  = 832,
   parameter  int PIXELS = 768,
   localparam int ADDRW  = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             subpage,
   output logic             busy,
   output logic             done,
   output logic [ADDRW-1:0] rom_addr,
   input  logic             rom_pg0,
   input  logic             rom_pg1,
   input  logic [15:0]      rom_offset,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ADDRW-1:0] out_addr,
   output logic [15:0]      out_offset,
   output logic             out_aux
);

   typedef enum logic [2:0] {IDLE, ADDR, DATA, OUT, DONE} state_t;

`ifdef MLX_SCAN_AUX_EN
   localparam logic [ADDRW-1:0] LAST   = ADDRW'(DEPTH - 1);
   localparam logic [ADDRW-1:0] PIX_LO = ADDRW'(PIXELS);
`else
   localparam logic [ADDRW-1:0] LAST   = ADDRW'(PIXELS - 1);
`endif

   state_t           state, state_n;
   logic             sub_q, sub_n;
   logic [ADDRW-1:0] addr_n, oaddr_n;
   logic [15:0]      ooff_n;
   logic             sel, is_aux;

`ifdef MLX_SCAN_AUX_EN
   logic aux_q, aux_n;
   // Aux words bypass the chess filter and are always emitted.
   assign is_aux  = (rom_addr >= PIX_LO);
   assign sel     = is_aux | (sub_q ? rom_pg1 : rom_pg0);
   assign out_aux = aux_q;
`else
   assign is_aux  = 1'b0;
   assign sel     = sub_q ? rom_pg1 : rom_pg0;
   assign out_aux = 1'b0;
`endif

   always_comb begin
      state_n = state;
      sub_n   = sub_q;
      addr_n  = rom_addr;
      oaddr_n = out_addr;
      ooff_n  = out_offset;
`ifdef MLX_SCAN_AUX_EN
      aux_n   = aux_q;
`endif
      case (state)
         IDLE: if (start) begin
            sub_n   = subpage;
            addr_n  = '0;
            state_n = ADDR;
         end
         ADDR: state_n = DATA;
         DATA: begin
            if (sel) begin
               oaddr_n = rom_addr;
               ooff_n  = rom_offset;
`ifdef MLX_SCAN_AUX_EN
               aux_n   = is_aux;
`endif
               state_n = OUT;
            end else if (rom_addr == LAST) begin
               state_n = DONE;
            end else begin
               addr_n  = rom_addr + ADDRW'(1);
               state_n = ADDR;
            end
         end
         OUT: if (out_ready) begin
            if (rom_addr == LAST) begin
               state_n = DONE;
            end else begin
               addr_n  = rom_addr + ADDRW'(1);
               state_n = ADDR;
            end
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Status outputs are registered from the next state so they align with it.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         sub_q      <= 1'b0;
         rom_addr   <= '0;
         out_addr   <= '0;
         out_offset <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         out_valid  <= 1'b0;
`ifdef MLX_SCAN_AUX_EN
         aux_q      <= 1'b0;
`endif
      end else begin
         state      <= state_n;
         sub_q      <= sub_n;
         rom_addr   <= addr_n;
         out_addr   <= oaddr_n;
         out_offset <= ooff_n;
         busy       <= (state_n == ADDR) || (state_n == DATA) || (state_n == OUT);
         done       <= (state_n == DONE);
         out_valid  <= (state_n == OUT);
`ifdef MLX_SCAN_AUX_EN
         aux_q      <= aux_n;
`endif
      end
   end

   // is_aux is only consumed by the aux build.
   logic unused_ok;
   assign unused_ok = is_aux;

endmodule
